debug_dump_tx: RTL and testbench

- Debug-side serializer for the MIPS debug link; the sending end of the post-run dump that the host's UART receiver collects.
- On i_start, captures the PC, then walks the register file and the data memory through their debug read ports.
- Sends every 32-bit word as 4 bytes, least significant byte first, through the UART transmitter handshake.
- Sits between the datapath debug ports and the UART tx side inside the top level.

---
 rtl/debug_pkg.sv | 40 ++++
 rtl/word_byte_serializer.sv | 56 +++++
 rtl/debug_dump_tx.sv | 241 ++++++++++++++++++++++++
 tb/tb_debug_dump_tx.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// debug_pkg
// Shared definitions for the post-run debug dump transmitter.
//
// Contents:
//   DEF_DATA_WIDTH / DEF_DATA_WIDTH_UART  default word and byte widths
//   BYTES_PER_WORD                        bytes sent per dumped word
//   state_t                               dump controller states
//   section_t                             which part of the dump is being sent
//   count_width()                         counter width helper
//
// The optional checksum byte (macro DEBUG_DUMP_CHECKSUM_EN) uses SEC_CSUM.

package debug_pkg;

    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_DATA_WIDTH_UART = 8;
    localparam int BYTES_PER_WORD      = DEF_DATA_WIDTH / DEF_DATA_WIDTH_UART;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        NEXT,
        FETCH,
        FINISH
    } state_t;

    typedef enum logic [1:0] {
        SEC_PC,
        SEC_REG,
        SEC_MEM,
        SEC_CSUM
    } section_t;

    // A counter over n items needs at least one bit, even when n is 1.
    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// word_byte_serializer
// Holds one latched word and presents it one byte at a time, least
// significant byte first. Shared by every section of the dump.
//
// Ports:
//   clock      system clock
//   reset_n    asynchronous active-low reset
//   load       capture load_word and restart at byte 0
//   load_word  word to capture
//   advance    step to the next byte (wraps after the last one)
//   tx_byte    currently selected byte
//   last_byte  high while the most significant byte is selected

module word_byte_serializer
    import debug_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int DATA_WIDTH_UART = DEF_DATA_WIDTH_UART,
    parameter int NBYTES          = BYTES_PER_WORD
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       load,
    input  logic [DATA_WIDTH-1:0]      load_word,
    input  logic                       advance,
    output logic [DATA_WIDTH_UART-1:0] tx_byte,
    output logic                       last_byte
);

    localparam int CNT_W = count_width(NBYTES);

    logic [NBYTES-1:0][DATA_WIDTH_UART-1:0] word_q;
    logic [CNT_W-1:0]                       byte_cnt_q;

    // The word is only ever replaced by an explicit load, so whatever the
    // read ports do while its bytes are going out cannot reach the wire.
    // Loading always restarts the byte counter at the low byte.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_q     <= '0;
            byte_cnt_q <= '0;
        end else if (load) begin
            word_q     <= load_word;
            byte_cnt_q <= '0;
        end else if (advance) begin
            byte_cnt_q <= last_byte ? '0 : byte_cnt_q + CNT_W'(1);
        end
    end

    // Byte selection straight off the packed byte array.
    always_comb begin
        tx_byte   = word_q[byte_cnt_q];
        last_byte = (byte_cnt_q == CNT_W'(NBYTES - 1));
    end

endmodule

// File: rtl/debug_dump_tx.sv
// debug_dump_tx
// Sending end of the post-run debug dump. On i_start it captures the PC,
// then walks the register file and the data memory through their
// synchronous debug read ports, sending every word as bytes, least
// significant byte first, through the UART tx handshake.
// Stream order: PC, reg0..reg(NREGS-1), mem0..mem(NMEM-1).
//
// Optional feature (macro DEBUG_DUMP_CHECKSUM_EN): one extra byte, the XOR
// of every preceding dump byte, is sent after the last memory byte.
//
// Ports:
//   i_clock      system clock
//   i_reset      asynchronous active-low reset
//   i_start      one-cycle pulse, begin a dump (ignored while busy)
//   i_pc         program counter, captured on the accepted start
//   o_reg_addr   register-file debug read address
//   i_reg_data   register data, one cycle after o_reg_addr
//   o_mem_addr   data-memory debug read address (word index)
//   i_mem_data   memory data, one cycle after o_mem_addr
//   o_tx_signal  one-cycle request to the UART transmitter
//   o_tx_byte    byte to send, stable until i_tx_done
//   i_tx_done    one-cycle pulse, UART finished the current byte
//   o_busy       dump in progress
//   o_done       one-cycle pulse after the final byte is acknowledged

module debug_dump_tx
    import debug_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int DATA_WIDTH_UART = DEF_DATA_WIDTH_UART,
    parameter int NREGS           = 32,
    parameter int NMEM            = 32,
    parameter int ADDR_WIDTH      = 5
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic [DATA_WIDTH-1:0]      i_pc,
    output logic [ADDR_WIDTH-1:0]      o_reg_addr,
    input  logic [DATA_WIDTH-1:0]      i_reg_data,
    output logic [ADDR_WIDTH-1:0]      o_mem_addr,
    input  logic [DATA_WIDTH-1:0]      i_mem_data,
    output logic                       o_tx_signal,
    output logic [DATA_WIDTH_UART-1:0] o_tx_byte,
    input  logic                       i_tx_done,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int NBYTES = DATA_WIDTH / DATA_WIDTH_UART;

    state_t                  state_q, state_d;
    section_t                section_q, section_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   reg_addr_q, reg_addr_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic                    fetch_phase_q, fetch_phase_d;

    logic                       load;
    logic [DATA_WIDTH-1:0]      load_word;
    logic                       advance;
    logic [DATA_WIDTH_UART-1:0] tx_byte;
    logic                       last_byte;

`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH_UART-1:0] csum_q, csum_d;
`endif

    word_byte_serializer #(
        .DATA_WIDTH      (DATA_WIDTH),
        .DATA_WIDTH_UART (DATA_WIDTH_UART),
        .NBYTES          (NBYTES)
    ) u_serializer (
        .clock     (i_clock),
        .reset_n   (i_reset),
        .load      (load),
        .load_word (load_word),
        .advance   (advance),
        .tx_byte   (tx_byte),
        .last_byte (last_byte)
    );

    // Controller registers. The read addresses live here so they hold their
    // last value between fetches; a reset mid-dump drops straight to IDLE.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q       <= IDLE;
            section_q     <= SEC_PC;
            idx_q         <= '0;
            reg_addr_q    <= '0;
            mem_addr_q    <= '0;
            fetch_phase_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            section_q     <= section_d;
            idx_q         <= idx_d;
            reg_addr_q    <= reg_addr_d;
            mem_addr_q    <= mem_addr_d;
            fetch_phase_q <= fetch_phase_d;
        end
    end

`ifdef DEBUG_DUMP_CHECKSUM_EN
    // Running XOR of every byte put on the wire during this dump.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    // Next-state logic. FETCH spends two cycles: the first lets the new
    // address reach the synchronous read port, the second captures the data
    // that port returns. i_tx_done only matters in WAIT, and the checksum
    // byte is a single-byte word that finishes after its first acknowledge.
    always_comb begin
        state_d       = state_q;
        section_d     = section_q;
        idx_d         = idx_q;
        reg_addr_d    = reg_addr_q;
        mem_addr_d    = mem_addr_q;
        fetch_phase_d = fetch_phase_q;
        load          = 1'b0;
        load_word     = i_pc;
        advance       = 1'b0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
        csum_d        = csum_q;
`endif

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    load          = 1'b1;
                    load_word     = i_pc;
                    section_d     = SEC_PC;
                    idx_d         = '0;
                    fetch_phase_d = 1'b0;
                    state_d       = SEND;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    csum_d        = '0;
`endif
                end
            end

            SEND: begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                csum_d  = csum_q ^ tx_byte;
`endif
                state_d = WAIT;
            end

            WAIT: begin
                if (i_tx_done) begin
                    advance = 1'b1;
                    if (section_q == SEC_CSUM) begin
                        state_d = FINISH;
                    end else if (last_byte) begin
                        state_d = NEXT;
                    end else begin
                        state_d = SEND;
                    end
                end
            end

            NEXT: begin
                fetch_phase_d = 1'b0;
                case (section_q)
                    SEC_PC: begin
                        section_d  = SEC_REG;
                        idx_d      = '0;
                        reg_addr_d = '0;
                        state_d    = FETCH;
                    end
                    SEC_REG: begin
                        if (idx_q == ADDR_WIDTH'(NREGS - 1)) begin
                            section_d  = SEC_MEM;
                            idx_d      = '0;
                            mem_addr_d = '0;
                        end else begin
                            idx_d      = idx_q + ADDR_WIDTH'(1);
                            reg_addr_d = idx_q + ADDR_WIDTH'(1);
                        end
                        state_d = FETCH;
                    end
                    SEC_MEM: begin
                        if (idx_q == ADDR_WIDTH'(NMEM - 1)) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                            section_d = SEC_CSUM;
                            load      = 1'b1;
                            load_word = DATA_WIDTH'(csum_q);
                            state_d   = SEND;
`else
                            state_d   = FINISH;
`endif
                        end else begin
                            idx_d      = idx_q + ADDR_WIDTH'(1);
                            mem_addr_d = idx_q + ADDR_WIDTH'(1);
                            state_d    = FETCH;
                        end
                    end
                    default: begin
                        state_d = FINISH;
                    end
                endcase
            end

            FETCH: begin
                if (!fetch_phase_q) begin
                    fetch_phase_d = 1'b1;
                end else begin
                    fetch_phase_d = 1'b0;
                    load          = 1'b1;
                    load_word     = (section_q == SEC_REG) ? i_reg_data : i_mem_data;
                    state_d       = SEND;
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state, so reset clears them
    // without waiting for a clock.
    always_comb begin
        o_tx_signal = (state_q == SEND);
        o_done      = (state_q == FINISH);
        o_busy      = (state_q != IDLE);
        o_tx_byte   = tx_byte;
        o_reg_addr  = reg_addr_q;
        o_mem_addr  = mem_addr_q;
    end

endmodule

// File: tb/tb_debug_dump_tx.sv
// tb_debug_dump_tx
// Self-checking bench for debug_dump_tx. A UART-side responder acknowledges
// each request three cycles later and records the bytes; the expected byte
// stream is built from the PC, register and memory contents as a list of
// words split into bytes, least significant first.
// Define DEBUG_DUMP_CHECKSUM_EN for both bench and RTL to cover the
// checksum byte.

module tb_debug_dump_tx;

    localparam int DW    = 32;
    localparam int UW    = 8;
    localparam int NREGS = 32;
    localparam int NMEM  = 32;
    localparam int AW    = 5;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    localparam int TOTAL = 4 * (1 + NREGS + NMEM) + 1;
`else
    localparam int TOTAL = 4 * (1 + NREGS + NMEM);
`endif
    localparam int DONE_BUDGET = 4000;

    logic          i_clock;
    logic          i_reset;
    logic          i_start;
    logic [DW-1:0] i_pc;
    logic [AW-1:0] o_reg_addr;
    logic [DW-1:0] i_reg_data;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] i_mem_data;
    logic          o_tx_signal;
    logic [UW-1:0] o_tx_byte;
    logic          i_tx_done;
    logic          o_busy;
    logic          o_done;

    debug_dump_tx #(
        .DATA_WIDTH      (DW),
        .DATA_WIDTH_UART (UW),
        .NREGS           (NREGS),
        .NMEM            (NMEM),
        .ADDR_WIDTH      (AW)
    ) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_pc        (i_pc),
        .o_reg_addr  (o_reg_addr),
        .i_reg_data  (i_reg_data),
        .o_mem_addr  (o_mem_addr),
        .i_mem_data  (i_mem_data),
        .o_tx_signal (o_tx_signal),
        .o_tx_byte   (o_tx_byte),
        .i_tx_done   (i_tx_done),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] regs [NREGS];
    logic [DW-1:0] mems [NMEM];
    logic [DW-1:0] reg_rd_q, mem_rd_q;
    logic [DW-1:0] corrupt_val;
    bit            corrupt_en = 0;
    bit            spurious_en = 0;

    bit            pending = 0;
    int            ack_cnt = 0;
    logic [UW-1:0] pend_byte;
    logic [UW-1:0] captured [$];
    logic [UW-1:0] expected [$];
    int            done_count = 0;
    int            protocol_errs = 0;
    logic          done_mon = 1'b0;
    logic          done_force = 1'b0;

    // Clock generation
    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    // Synchronous-read model of the register file and data memory. While a
    // byte is outstanding the ports carry garbage when corruption is enabled.
    always @(posedge i_clock) begin
        reg_rd_q <= regs[o_reg_addr];
        mem_rd_q <= mems[o_mem_addr];
    end
    assign i_reg_data = (corrupt_en && pending) ? corrupt_val : reg_rd_q;
    assign i_mem_data = (corrupt_en && pending) ? ~corrupt_val : mem_rd_q;
    assign i_tx_done  = done_mon | done_force;

    // UART responder: records each request, acknowledges it three cycles
    // later, watches that the byte stays put and the request is one cycle,
    // and optionally sprinkles stray acknowledges when nothing is pending.
    always @(negedge i_clock) begin
        corrupt_val = $urandom;
        if (!i_reset) begin
            pending  = 0;
            done_mon = 1'b0;
        end else begin
            if (o_done) done_count++;
            if (pending) begin
                if (o_tx_signal) protocol_errs++;
                if (o_tx_byte !== pend_byte) protocol_errs++;
                ack_cnt--;
                if (ack_cnt == 0) begin
                    done_mon = 1'b1;
                    pending  = 0;
                end else begin
                    done_mon = 1'b0;
                end
            end else if (o_tx_signal) begin
                captured.push_back(o_tx_byte);
                pend_byte = o_tx_byte;
                pending   = 1;
                ack_cnt   = 3;
                if (o_busy !== 1'b1) protocol_errs++;
                done_mon  = spurious_en ? ($urandom_range(0, 1) == 1) : 1'b0;
            end else begin
                done_mon  = spurious_en ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
        end
    end

    // Reference stream: the PC, every register, every memory word, each as
    // four bytes low byte first, then the XOR of all of them when enabled.
    function automatic void build_expected(input logic [DW-1:0] pc);
        logic [DW-1:0] words [$];
        logic [UW-1:0] x;
        expected.delete();
        words.push_back(pc);
        for (int k = 0; k < NREGS; k++) words.push_back(regs[k]);
        for (int k = 0; k < NMEM; k++)  words.push_back(mems[k]);
        x = '0;
        foreach (words[w]) begin
            for (int b = 0; b < 4; b++) begin
                expected.push_back(words[w][8*b +: 8]);
                x ^= words[w][8*b +: 8];
            end
        end
`ifdef DEBUG_DUMP_CHECKSUM_EN
        expected.push_back(x);
`endif
    endfunction

    function automatic int first_diff();
        int n;
        n = (captured.size() < expected.size()) ? captured.size() : expected.size();
        for (int i = 0; i < n; i++) begin
            if (captured[i] !== expected[i]) return i;
        end
        return -1;
    endfunction

    task automatic clear_run();
        captured.delete();
        done_count    = 0;
        protocol_errs = 0;
    endtask

    task automatic start_dump(input bit with_done);
        @(negedge i_clock);
        #1;
        i_start    = 1'b1;
        done_force = with_done;
        @(negedge i_clock);
        #1;
        i_start    = 1'b0;
        done_force = 1'b0;
    endtask

    task automatic wait_done(input bit poke_start, output bit ok);
        int c = 0;
        while (done_count == 0 && c < DONE_BUDGET) begin
            @(negedge i_clock);
            c++;
            if (poke_start && o_busy && $urandom_range(0, 59) == 0) begin
                #1;
                i_start = 1'b1;
                @(negedge i_clock);
                #1;
                i_start = 1'b0;
                c++;
            end
        end
        ok = (done_count != 0);
        repeat (6) @(negedge i_clock);
    endtask

    task automatic fill_pattern();
        for (int k = 0; k < NREGS; k++) regs[k] = 32'h100 + k;
        for (int k = 0; k < NMEM; k++)  mems[k] = 32'hA000_0000 + k;
    endtask

    task automatic test_reset();
        bit seen_activity = 0;
        bit addr_moved    = 0;
        i_reset = 1'b0;
        repeat (3) @(negedge i_clock);
        checks++;
        if (o_tx_signal !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: tx_signal=%b busy=%b done=%b, wanted 0 0 0",
                     o_tx_signal, o_busy, o_done);
        end
        checks++;
        if (o_reg_addr !== '0 || o_mem_addr !== '0 || o_tx_byte !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: reg_addr=%0d mem_addr=%0d tx_byte=%h, wanted 0 0 00",
                     o_reg_addr, o_mem_addr, o_tx_byte);
        end
        @(negedge i_clock);
        #1;
        i_reset = 1'b1;
        repeat (20) begin
            @(negedge i_clock);
            if (o_tx_signal !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) seen_activity = 1;
            if (o_reg_addr !== '0 || o_mem_addr !== '0) addr_moved = 1;
        end
        checks++;
        if (seen_activity) begin
            errors++;
            $display("[TB] FAIL idle_quiet: outputs toggled with no start, wanted all 0");
        end
        checks++;
        if (addr_moved) begin
            errors++;
            $display("[TB] FAIL idle_addr: read addresses moved with no start, wanted 0");
        end
    endtask

    task automatic test_basic_dump();
        bit ok;
        logic [UW-1:0] head [8];
        logic [UW-1:0] tail [4];
        logic [UW-1:0] x;
        int d;
        head = '{8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
        tail = '{8'h1F, 8'h00, 8'h00, 8'hA0};
        fill_pattern();
        i_pc = 32'h0000_0034;
        clear_run();
        build_expected(32'h0000_0034);
        start_dump(0);
        wait_done(0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL basic_timeout: no o_done within %0d cycles", DONE_BUDGET);
        end
        checks++;
        if (captured.size() != TOTAL) begin
            errors++;
            $display("[TB] FAIL basic_count: got %0d bytes, wanted %0d", captured.size(), TOTAL);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (captured.size() <= i || captured[i] !== head[i]) begin
                errors++;
                $display("[TB] FAIL basic_head[%0d]: got %h, wanted %h",
                         i, (captured.size() > i) ? captured[i] : 8'hxx, head[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (captured.size() <= 256 + i || captured[256+i] !== tail[i]) begin
                errors++;
                $display("[TB] FAIL basic_tail[%0d]: got %h, wanted %h",
                         i, (captured.size() > 256 + i) ? captured[256+i] : 8'hxx, tail[i]);
            end
        end
`ifdef DEBUG_DUMP_CHECKSUM_EN
        x = '0;
        for (int i = 0; i < 260; i++) x ^= expected[i];
        checks++;
        if (captured.size() <= 260 || captured[260] !== x) begin
            errors++;
            $display("[TB] FAIL basic_csum: got %h, wanted %h",
                     (captured.size() > 260) ? captured[260] : 8'hxx, x);
        end
`else
        x = '0;
`endif
        d = first_diff();
        checks++;
        if (d >= 0) begin
            errors++;
            $display("[TB] FAIL basic_stream: byte %0d got %h, wanted %h", d, captured[d], expected[d]);
        end
        checks++;
        if (done_count != 1) begin
            errors++;
            $display("[TB] FAIL basic_done: saw %0d o_done pulses, wanted 1", done_count);
        end
        checks++;
        if (protocol_errs != 0) begin
            errors++;
            $display("[TB] FAIL basic_handshake: %0d handshake violations, wanted 0", protocol_errs);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_idle: busy=%b after dump, wanted 0", o_busy);
        end
    endtask

    // Random contents, garbage on the read ports and a changing i_pc while
    // words are in flight, stray acknowledges, start pulses while busy, and
    // on the first pass a start coinciding with i_tx_done in IDLE.
    task automatic test_random_dump();
        bit ok;
        int d;
        logic [DW-1:0] pc;
        for (int iter = 0; iter < 3; iter++) begin
            for (int k = 0; k < NREGS; k++) regs[k] = $urandom;
            for (int k = 0; k < NMEM; k++)  mems[k] = $urandom;
            pc = $urandom;
            i_pc = pc;
            clear_run();
            build_expected(pc);
            corrupt_en  = 1;
            spurious_en = 1;
            start_dump(iter == 0);
            i_pc = $urandom;
            wait_done(1, ok);
            corrupt_en  = 0;
            spurious_en = 0;
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL rand%0d_timeout: no o_done within %0d cycles", iter, DONE_BUDGET);
            end
            checks++;
            if (captured.size() != TOTAL) begin
                errors++;
                $display("[TB] FAIL rand%0d_count: got %0d bytes, wanted %0d", iter, captured.size(), TOTAL);
            end
            d = first_diff();
            checks++;
            if (d >= 0) begin
                errors++;
                $display("[TB] FAIL rand%0d_stream: byte %0d got %h, wanted %h",
                         iter, d, captured[d], expected[d]);
            end
            checks++;
            if (done_count != 1 || protocol_errs != 0) begin
                errors++;
                $display("[TB] FAIL rand%0d_proto: done=%0d violations=%0d, wanted 1 and 0",
                         iter, done_count, protocol_errs);
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        bit ok;
        int c = 0;
        int d;
        fill_pattern();
        i_pc = 32'h0000_0034;
        clear_run();
        build_expected(32'h0000_0034);
        start_dump(0);
        while (captured.size() < 100 && c < DONE_BUDGET) begin
            @(negedge i_clock);
            c++;
        end
        checks++;
        if (captured.size() < 100) begin
            errors++;
            $display("[TB] FAIL abort_progress: got %0d bytes, wanted at least 100", captured.size());
        end
        #2;
        i_reset = 1'b0;
        #1;
        checks++;
        if (o_tx_signal !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_tx_byte !== '0) begin
            errors++;
            $display("[TB] FAIL abort_ctrl: tx_signal=%b busy=%b done=%b tx_byte=%h, wanted 0 0 0 00",
                     o_tx_signal, o_busy, o_done, o_tx_byte);
        end
        checks++;
        if (o_reg_addr !== '0 || o_mem_addr !== '0) begin
            errors++;
            $display("[TB] FAIL abort_addr: reg_addr=%0d mem_addr=%0d, wanted 0 0", o_reg_addr, o_mem_addr);
        end
        repeat (3) @(negedge i_clock);
        checks++;
        if (done_count != 0) begin
            errors++;
            $display("[TB] FAIL abort_done: saw %0d o_done pulses, wanted 0", done_count);
        end
        #1;
        i_reset = 1'b1;
        clear_run();
        start_dump(0);
        wait_done(0, ok);
        d = first_diff();
        checks++;
        if (!ok || captured.size() != TOTAL || d >= 0) begin
            errors++;
            $display("[TB] FAIL restart_stream: done=%0d bytes=%0d first_diff=%0d, wanted done and %0d bytes matching",
                     ok, captured.size(), d, TOTAL);
        end
    endtask

    initial begin
        i_reset    = 1'b0;
        i_start    = 1'b0;
        i_pc       = '0;
        test_reset();
        test_basic_dump();
        test_random_dump();
        test_reset_mid_dump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
